// File: rtl/phrase_packer_pkg.sv
// Shared helpers for phrase_packer: word-slot bit offsets and the flush keep mask.
package phrase_packer_pkg;

    localparam int MAX_RATIO = 64;

    function automatic int slot_lsb(input int idx, input int ratio, input int word_w, input bit msw_first);
        return msw_first ? (ratio - 1 - idx) * word_w : idx * word_w;
    endfunction

    // Bits 0..count-1 set; only the low RATIO bits are meaningful to callers.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int count, input int ratio);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            m[i] = (i < count) && (i < ratio);
        end
        return m;
    endfunction

endpackage

// File: rtl/phrase_packer_if.sv
// Word-in / phrase-out stream bundle for phrase_packer; keep_out exists only with PHRASE_KEEP_EN.
interface phrase_packer_if #(
    parameter int WORD_W = 16,
    parameter int RATIO  = 8
);
    localparam int PH_W = WORD_W * RATIO;

    logic              valid_in;
    logic              ready_in;
    logic [WORD_W-1:0] data_in;
    logic              newframe_in;
    logic              valid_out;
    logic              ready_out;
    logic [PH_W-1:0]   data_out;
    logic              tuser_out;
`ifdef PHRASE_KEEP_EN
    logic [RATIO-1:0]  keep_out;

    modport master (
        output valid_in, data_in, newframe_in, ready_out,
        input  ready_in, valid_out, data_out, tuser_out, keep_out
    );
    modport slave (
        input  valid_in, data_in, newframe_in, ready_out,
        output ready_in, valid_out, data_out, tuser_out, keep_out
    );
`else
    modport master (
        output valid_in, data_in, newframe_in, ready_out,
        input  ready_in, valid_out, data_out, tuser_out
    );
    modport slave (
        input  valid_in, data_in, newframe_in, ready_out,
        output ready_in, valid_out, data_out, tuser_out
    );
`endif

endinterface

// File: rtl/phrase_packer_slot_counter.sv
// Word-slot counter for phrase_packer: increments with natural wrap, or restarts at one after a flush.
module slot_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             incr_i,
    input  logic             load_one_i,
    output logic             wrap_o,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // next slot index
    always_comb begin
        if (load_one_i) begin
            count_d = ONE;
        end else if (incr_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // slot index register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = (count_q == {WIDTH{1'b1}});

endmodule

// File: rtl/phrase_packer.sv
// N:1 stream width packer: WORD_W-bit words into RATIO-word phrases, partial-phrase flush on newframe.
// Define PHRASE_KEEP_EN to add the registered per-word keep_out mask.
module phrase_packer
    import phrase_packer_pkg::*;
#(
    parameter int                WORD_W    = 16,
    parameter int                RATIO     = 8,
    parameter bit                MSW_FIRST = 1'b1,
    parameter logic [WORD_W-1:0] PAD_WORD  = '0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    phrase_packer_if.slave bus
);

    localparam int PH_W = WORD_W * RATIO;
    localparam int CW   = $clog2(RATIO);
    localparam int LW   = $clog2(PH_W);

    logic [CW-1:0]   count_s;
    logic            wrap_s;
    logic            slot_free_s;
    logic            flush_req_s;
    logic            accept_s;
    logic            take_s;
    logic            flush_s;
    logic [PH_W-1:0] phrase_full_s;
    logic [PH_W-1:0] phrase_pad_s;
    logic [PH_W-1:0] fresh_s;

    logic [PH_W-1:0] acc_q, acc_d;
    logic            pend_tuser_q, pend_tuser_d;
    logic            out_valid_q, out_valid_d;
    logic [PH_W-1:0] out_data_q, out_data_d;
    logic            out_tuser_q, out_tuser_d;
`ifdef PHRASE_KEEP_EN
    logic [RATIO-1:0] out_keep_q, out_keep_d;
`endif

    // A full phrase or a flush needs the output slot; otherwise the word only touches the accumulator.
    assign slot_free_s  = ~out_valid_q | bus.ready_out;
    assign flush_req_s  = bus.newframe_in & (count_s != '0);
    assign bus.ready_in = slot_free_s | ~(wrap_s | flush_req_s);
    assign accept_s     = bus.valid_in & bus.ready_in;
    assign take_s       = out_valid_q & bus.ready_out;
    assign flush_s      = accept_s & flush_req_s;

    slot_counter #(.WIDTH(CW)) u_slot_counter (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .incr_i     (accept_s & ~flush_req_s),
        .load_one_i (flush_s),
        .wrap_o     (wrap_s),
        .count_o    (count_s)
    );

    // candidate phrases: current word merged, padded partial, and a fresh phrase for a flush
    always_comb begin
        phrase_full_s = acc_q;
        phrase_full_s[LW'(slot_lsb(int'(count_s), RATIO, WORD_W, MSW_FIRST)) +: WORD_W] = bus.data_in;
        phrase_pad_s = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            phrase_pad_s[LW'(slot_lsb(i, RATIO, WORD_W, MSW_FIRST)) +: WORD_W] =
                (i >= int'(count_s)) ? PAD_WORD : acc_q[LW'(slot_lsb(i, RATIO, WORD_W, MSW_FIRST)) +: WORD_W];
        end
        fresh_s = acc_q;
        fresh_s[LW'(slot_lsb(0, RATIO, WORD_W, MSW_FIRST)) +: WORD_W] = bus.data_in;
    end

    // accumulator, pending frame flag and output register next state
    always_comb begin
        acc_d        = acc_q;
        pend_tuser_d = pend_tuser_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tuser_d  = out_tuser_q;
`ifdef PHRASE_KEEP_EN
        out_keep_d   = out_keep_q;
`endif
        if (flush_s) begin
            acc_d        = fresh_s;
            pend_tuser_d = 1'b1;
            out_valid_d  = 1'b1;
            out_data_d   = phrase_pad_s;
            out_tuser_d  = pend_tuser_q;
`ifdef PHRASE_KEEP_EN
            out_keep_d   = RATIO'(keep_mask(int'(count_s), RATIO));
`endif
        end else if (accept_s) begin
            acc_d        = phrase_full_s;
            pend_tuser_d = (count_s == '0) ? bus.newframe_in : pend_tuser_q;
            if (wrap_s) begin
                out_valid_d = 1'b1;
                out_data_d  = phrase_full_s;
                out_tuser_d = pend_tuser_q;
`ifdef PHRASE_KEEP_EN
                out_keep_d  = '1;
`endif
            end else begin
                out_valid_d = out_valid_q & ~take_s;
            end
        end else begin
            out_valid_d = out_valid_q & ~take_s;
        end
    end

    // state registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q        <= '0;
            pend_tuser_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tuser_q  <= 1'b0;
`ifdef PHRASE_KEEP_EN
            out_keep_q   <= '0;
`endif
        end else begin
            acc_q        <= acc_d;
            pend_tuser_q <= pend_tuser_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tuser_q  <= out_tuser_d;
`ifdef PHRASE_KEEP_EN
            out_keep_q   <= out_keep_d;
`endif
        end
    end

    assign bus.valid_out = out_valid_q;
    assign bus.data_out  = out_data_q;
    assign bus.tuser_out = out_tuser_q;
`ifdef PHRASE_KEEP_EN
    assign bus.keep_out  = out_keep_q;
`endif

endmodule

// File: tb/tb_phrase_packer.sv
// Self-checking bench for phrase_packer against a queue-based phrase model; keep_out checked with PHRASE_KEEP_EN.
module tb_phrase_packer;

    localparam int WORD_W = 16;
    localparam int RATIO  = 8;
    localparam int PH_W   = WORD_W * RATIO;
    localparam logic [WORD_W-1:0] PAD = 16'h0000;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    phrase_packer_if #(.WORD_W(WORD_W), .RATIO(RATIO)) bus ();
    phrase_packer_if #(.WORD_W(WORD_W), .RATIO(RATIO)) bus2 ();

    phrase_packer #(.WORD_W(WORD_W), .RATIO(RATIO), .MSW_FIRST(1'b1), .PAD_WORD(PAD)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    phrase_packer #(.WORD_W(WORD_W), .RATIO(RATIO), .MSW_FIRST(1'b0), .PAD_WORD(PAD)) dut_lsw (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [WORD_W-1:0] m_part[$];
    logic              m_tuser;
    logic              m_out_valid;
    logic [PH_W-1:0]   m_out_data;
    logic              m_out_tuser;
    logic [PH_W-1:0]   got_data_q[$];
    logic              got_tuser_q[$];
`ifdef PHRASE_KEEP_EN
    logic [RATIO-1:0]  m_out_keep;
    logic [RATIO-1:0]  got_keep_q[$];
`endif

    function automatic logic [PH_W-1:0] build(input logic [WORD_W-1:0] q[$], input bit msw);
        logic [PH_W-1:0] p;
        p = '0;
        for (int w = 0; w < RATIO; w++) begin
            logic [WORD_W-1:0] val;
            val = (w < q.size()) ? q[w] : PAD;
            if (msw) p[(RATIO-1-w)*WORD_W +: WORD_W] = val;
            else     p[w*WORD_W +: WORD_W] = val;
        end
        return p;
    endfunction

    function automatic void model_reset();
        m_part.delete();
        m_tuser     = 1'b0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        m_out_tuser = 1'b0;
    endfunction

    function automatic void model_accept(input logic [WORD_W-1:0] d, input logic nf);
        if (nf && m_part.size() != 0) begin
            m_out_data  = build(m_part, 1'b1);
            m_out_tuser = m_tuser;
            m_out_valid = 1'b1;
`ifdef PHRASE_KEEP_EN
            m_out_keep  = RATIO'((32'd1 << m_part.size()) - 32'd1);
`endif
            m_part.delete();
            m_part.push_back(d);
            m_tuser = 1'b1;
        end else begin
            if (m_part.size() == 0) m_tuser = nf;
            m_part.push_back(d);
            if (m_part.size() == RATIO) begin
                m_out_data  = build(m_part, 1'b1);
                m_out_tuser = m_tuser;
                m_out_valid = 1'b1;
`ifdef PHRASE_KEEP_EN
                m_out_keep  = '1;
`endif
                m_part.delete();
            end
        end
    endfunction

    function automatic void clear_got();
        got_data_q.delete();
        got_tuser_q.delete();
`ifdef PHRASE_KEEP_EN
        got_keep_q.delete();
`endif
    endfunction

    // one clock: drive, check outputs and ready against the model, advance the model
    task automatic step(input logic v, input logic [WORD_W-1:0] d, input logic nf, input logic ro, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        bus.valid_in = v; bus.data_in = d; bus.newframe_in = nf; bus.ready_out = ro;
        #1;
        checks++;
        if (bus.valid_out !== m_out_valid) $display("FAIL valid_out: got %b want %b t=%0t", bus.valid_out, m_out_valid, $time);
        else passes++;
        if (m_out_valid) begin
            checks++;
            if (bus.data_out !== m_out_data) $display("FAIL data_out: got %h want %h t=%0t", bus.data_out, m_out_data, $time);
            else passes++;
            checks++;
            if (bus.tuser_out !== m_out_tuser) $display("FAIL tuser_out: got %b want %b t=%0t", bus.tuser_out, m_out_tuser, $time);
            else passes++;
`ifdef PHRASE_KEEP_EN
            checks++;
            if (bus.keep_out !== m_out_keep) $display("FAIL keep_out: got %b want %b t=%0t", bus.keep_out, m_out_keep, $time);
            else passes++;
`endif
        end
        exp_rdy = !(m_out_valid && !ro) || !((m_part.size() == RATIO-1) || (nf && m_part.size() != 0));
        checks++;
        if (bus.ready_in !== exp_rdy) $display("FAIL ready_in: got %b want %b t=%0t", bus.ready_in, exp_rdy, $time);
        else passes++;
        acc = v && exp_rdy;
        if (m_out_valid && ro) begin
            got_data_q.push_back(bus.data_out);
            got_tuser_q.push_back(bus.tuser_out);
`ifdef PHRASE_KEEP_EN
            got_keep_q.push_back(bus.keep_out);
`endif
            m_out_valid = 1'b0;
        end
        if (acc) model_accept(d, nf);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, acc);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic nf, input logic ro);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 32 && !acc; k++) step(1'b1, d, nf, ro, acc);
        checks++;
        if (!acc) $display("FAIL send_word: word %h not accepted within 32 cycles", d);
        else passes++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.tuser_out !== 1'b0 || bus.data_out !== '0)
            $display("FAIL reset_outputs: got v=%b u=%b d=%h want 0", bus.valid_out, bus.tuser_out, bus.data_out);
        else passes++;
        checks++;
        if (bus.ready_in !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready_in);
        else passes++;
`ifdef PHRASE_KEEP_EN
        checks++;
        if (bus.keep_out !== '0) $display("FAIL reset_keep: got %b want 0", bus.keep_out);
        else passes++;
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_two_phrases();
        clear_got();
        for (int i = 1; i <= 16; i++) send_word(16'(i), 1'b0, 1'b1);
        idle(2);
        checks++;
        if (got_data_q.size() != 2) $display("FAIL two_phrases_count: got %0d want 2", got_data_q.size());
        else passes++;
        checks++;
        if (got_data_q[0][127:112] !== 16'h0001 || got_data_q[0][15:0] !== 16'h0008)
            $display("FAIL phrase1_words: got %h/%h want 0001/0008", got_data_q[0][127:112], got_data_q[0][15:0]);
        else passes++;
        checks++;
        if (got_data_q[1][127:112] !== 16'h0009) $display("FAIL phrase2_word0: got %h want 0009", got_data_q[1][127:112]);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [WORD_W-1:0] nxt;
        logic [WORD_W-1:0] q1[$];
        int accepted;
        clear_got();
        for (int i = 0; i < 8; i++) begin
            send_word(16'h0101 + 16'(i), 1'b0, 1'b1);
            q1.push_back(16'h0101 + 16'(i));
        end
        nxt = 16'h0109;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, nxt, 1'b0, 1'b0, acc);
            if (acc) begin accepted++; nxt = nxt + 16'h0001; end
        end
        checks++;
        if (accepted != 7) $display("FAIL stall_accepts: got %0d want 7", accepted);
        else passes++;
        #1;
        checks++;
        if (bus.data_out !== build(q1, 1'b1) || bus.valid_out !== 1'b1)
            $display("FAIL stall_hold: got v=%b d=%h want 1/%h", bus.valid_out, bus.data_out, build(q1, 1'b1));
        else passes++;
        send_word(nxt, 1'b0, 1'b1);
        idle(2);
        checks++;
        if (got_data_q.size() != 2 || got_data_q[1][127:112] !== 16'h0109 || got_data_q[1][15:0] !== 16'h0110)
            $display("FAIL release_order: got n=%0d w0=%h w7=%h want 2/0109/0110", got_data_q.size(), got_data_q[1][127:112], got_data_q[1][15:0]);
        else passes++;
    endtask

    task automatic test_flush();
        clear_got();
        send_word(16'hAAAA, 1'b0, 1'b1);
        send_word(16'hBBBB, 1'b0, 1'b1);
        send_word(16'hCCCC, 1'b0, 1'b1);
        send_word(16'hDDDD, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_word(16'hE000 + 16'(i), 1'b0, 1'b1);
        idle(2);
        checks++;
        if (got_data_q[0] !== {16'hAAAA, 16'hBBBB, 16'hCCCC, 80'h0} || got_tuser_q[0] !== 1'b0)
            $display("FAIL flush_phrase: got %h u=%b want aaaabbbbcccc000.. u=0", got_data_q[0], got_tuser_q[0]);
        else passes++;
        checks++;
        if (got_data_q[1][127:112] !== 16'hDDDD || got_tuser_q[1] !== 1'b1)
            $display("FAIL after_flush: got w0=%h u=%b want dddd/1", got_data_q[1][127:112], got_tuser_q[1]);
        else passes++;
`ifdef PHRASE_KEEP_EN
        checks++;
        if (got_keep_q[0] !== 8'b0000_0111 || got_keep_q[1] !== 8'hFF)
            $display("FAIL flush_keep: got %b/%b want 00000111/11111111", got_keep_q[0], got_keep_q[1]);
        else passes++;
`endif
    endtask

    task automatic test_newframe_aligned();
        clear_got();
        for (int i = 0; i < 8; i++) send_word(16'h3000 + 16'(i), (i == 0) ? 1'b1 : 1'b0, 1'b1);
        idle(2);
        checks++;
        if (got_data_q.size() != 1 || got_tuser_q[0] !== 1'b1)
            $display("FAIL aligned_newframe: got n=%0d u=%b want 1/1", got_data_q.size(), got_tuser_q[0]);
        else passes++;
`ifdef PHRASE_KEEP_EN
        checks++;
        if (got_keep_q[0] !== 8'hFF) $display("FAIL aligned_keep: got %b want 11111111", got_keep_q[0]);
        else passes++;
`endif
    endtask

    task automatic test_async_reset();
        clear_got();
        for (int i = 0; i < 8; i++) send_word(16'h4000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_word(16'h4100 + 16'(i), 1'b0, 1'b0);
        @(negedge clk);
        bus.valid_in = 1'b0; bus.newframe_in = 1'b0; bus.ready_out = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== '0 || bus.tuser_out !== 1'b0)
            $display("FAIL async_reset: got v=%b d=%h u=%b want 0", bus.valid_out, bus.data_out, bus.tuser_out);
        else passes++;
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) send_word(16'h0501 + 16'(i), 1'b0, 1'b1);
        idle(2);
        checks++;
        if (got_data_q.size() != 1 || got_data_q[0][127:112] !== 16'h0501 || got_data_q[0][15:0] !== 16'h0508)
            $display("FAIL post_reset_phrase: got n=%0d w0=%h w7=%h want 1/0501/0508", got_data_q.size(), got_data_q[0][127:112], got_data_q[0][15:0]);
        else passes++;
    endtask

    task automatic test_lsw_order();
        logic [WORD_W-1:0] q[$];
        idle(2);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus2.valid_in = 1'b1; bus2.data_in = 16'(i); bus2.newframe_in = 1'b0; bus2.ready_out = 1'b0;
            q.push_back(16'(i));
        end
        @(negedge clk);
        bus2.valid_in = 1'b0;
        #1;
        checks++;
        if (bus2.valid_out !== 1'b1 || bus2.data_out[15:0] !== 16'h0001 || bus2.data_out[127:112] !== 16'h0008)
            $display("FAIL lsw_order: got v=%b w[15:0]=%h w[127:112]=%h want 1/0001/0008", bus2.valid_out, bus2.data_out[15:0], bus2.data_out[127:112]);
        else passes++;
        checks++;
        if (bus2.data_out !== build(q, 1'b0)) $display("FAIL lsw_phrase: got %h want %h", bus2.data_out, build(q, 1'b0));
        else passes++;
        bus2.ready_out = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus2.valid_out !== 1'b0) $display("FAIL lsw_take: got %b want 0", bus2.valid_out);
        else passes++;
    endtask

    task automatic test_random();
        logic v, nf, ro, acc;
        logic [WORD_W-1:0] d;
        v = 1'b0; nf = 1'b0; d = 16'h0000;
        for (int n = 0; n < 600; n++) begin
            if (!v) begin
                v  = ($urandom_range(0, 3) != 0);
                d  = 16'($urandom);
                nf = ($urandom_range(0, 9) == 0);
            end
            ro = ($urandom_range(0, 2) != 0);
            step(v, d, nf, ro, acc);
            if (acc) v = 1'b0;
        end
        idle(3);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.valid_in = 1'b0; bus.data_in = 16'h0000; bus.newframe_in = 1'b0; bus.ready_out = 1'b1;
        bus2.valid_in = 1'b0; bus2.data_in = 16'h0000; bus2.newframe_in = 1'b0; bus2.ready_out = 1'b1;
        model_reset();
        test_reset();
        test_two_phrases();
        test_backpressure();
        test_flush();
        test_newframe_aligned();
        test_async_reset();
        test_lsw_order();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
